// File: rtl/lsu_avalon_bridge.sv
// Load/store unit to Avalon-MM master bridge: one access at a time, pipeline stalled while in flight.
// Handles byte/half/word lane steering, load alignment and extension, misalignment and read-timeout faults.
//
// state   | meaning
// IDLE    | waiting for an aligned load/store from the MEM stage
// WR      | avm_write held until the slave drops waitrequest
// RD_REQ  | avm_read held until the slave drops waitrequest
// RD_WAIT | read accepted, waiting for readdatavalid or timeout
// DONE    | one-cycle release of the stall before returning to IDLE
module lsu_avalon_bridge #(
    parameter int ADDR_W     = 32,
    parameter int RD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              mem_we,
    input  logic              mem_re,
    input  logic [2:0]        mem_size,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              mem_fault,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, WR, RD_REQ, RD_WAIT, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_lo;
    logic [2:0]        r_size;
    logic              r_avm_read;
    logic              r_avm_write;
    logic [ADDR_W-1:0] r_avm_address;
    logic [31:0]       r_avm_writedata;
    logic [3:0]        r_avm_be;
    logic [31:0]       r_rdata;
    logic              r_fault;

    logic              w_req;
    logic              w_is_byte;
    logic              w_is_half;
    logic              w_misalign;
    logic              w_start;
    logic              w_stall;
    logic              w_capture;
    logic              w_timeout;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;

    always_comb begin
        w_req      = mem_we | mem_re;
        w_is_byte  = (mem_size[1:0] == 2'b00);
        w_is_half  = (mem_size[1:0] == 2'b01);
        w_misalign = (w_is_half & mem_addr[0]) |
                     (~w_is_byte & ~w_is_half & (mem_addr[1:0] != 2'b00));
        w_start    = w_req & ~w_misalign;

        if (w_is_byte) begin
            w_be    = 4'b0001 << mem_addr[1:0];
            w_wdata = {4{mem_wdata[7:0]}};
        end else if (w_is_half) begin
            w_be    = 4'b0011 << mem_addr[1:0];
            w_wdata = {2{mem_wdata[15:0]}};
        end else begin
            w_be    = 4'b1111;
            w_wdata = mem_wdata;
        end

        // BU/HU differ from B/H only in funct3 bit 2, which suppresses sign extension
        w_shifted = avm_readdata >> {r_lo, 3'b000};
        case (r_size[1:0])
            2'b00:   w_load = {{24{w_shifted[7] & ~r_size[2]}}, w_shifted[7:0]};
            2'b01:   w_load = {{16{w_shifted[15] & ~r_size[2]}}, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_stall = 1'b1;
                    w_next  = mem_we ? WR : RD_REQ;
                end
            end
            WR: begin
                w_stall = 1'b1;
                if (!avm_waitrequest) w_next = DONE;
            end
            RD_REQ: begin
                w_stall = 1'b1;
                if (!avm_waitrequest) w_next = avm_readdatavalid ? DONE : RD_WAIT;
            end
            RD_WAIT: begin
                w_stall = 1'b1;
                if (avm_readdatavalid || (r_cnt == '0)) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_capture = avm_readdatavalid &
                       (((r_state == RD_REQ) & ~avm_waitrequest) | (r_state == RD_WAIT));
    assign w_timeout = (r_state == RD_WAIT) & ~avm_readdatavalid & (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt           <= '0;
            r_lo            <= '0;
            r_size          <= '0;
            r_avm_read      <= 1'b0;
            r_avm_write     <= 1'b0;
            r_avm_address   <= '0;
            r_avm_writedata <= '0;
            r_avm_be        <= '0;
            r_rdata         <= '0;
            r_fault         <= 1'b0;
        end else begin
            r_fault <= ((r_state == IDLE) & w_req & w_misalign) | w_timeout;

            if ((r_state == IDLE) && w_start) begin
                r_avm_address   <= {mem_addr[ADDR_W-1:2], 2'b00};
                r_avm_writedata <= w_wdata;
                r_avm_be        <= w_be;
                r_lo            <= mem_addr[1:0];
                r_size          <= mem_size;
                r_avm_write     <= mem_we;
                r_avm_read      <= ~mem_we;
            end
            if ((r_state == WR) && !avm_waitrequest)     r_avm_write <= 1'b0;
            if ((r_state == RD_REQ) && !avm_waitrequest) r_avm_read  <= 1'b0;

            // Down-counter gives RD_TIMEOUT cycles in RD_WAIT before the abort
            if (r_state == RD_REQ)
                r_cnt <= CNT_W'(RD_TIMEOUT - 1);
            else if ((r_state == RD_WAIT) && (r_cnt != '0))
                r_cnt <= r_cnt - 1'b1;

            if (w_capture)      r_rdata <= w_load;
            else if (w_timeout) r_rdata <= '0;
        end
    end

    assign mem_stall      = w_stall & ~rst;
    assign mem_fault      = r_fault;
    assign mem_rdata      = r_rdata;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_writedata  = r_avm_writedata;
    assign avm_byteenable = r_avm_be;

endmodule

// File: tb/tb_lsu_avalon_bridge.sv
// Self-checking bench for lsu_avalon_bridge: directed scenarios plus randomized accesses
// checked against an arithmetic model of lane steering, extension, latency and faults.
module tb_lsu_avalon_bridge;

    localparam int RD_TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_stall, mem_fault;
    logic [2:0]  mem_size;
    logic [31:0] avm_address, avm_writedata, avm_readdata;
    logic        avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
    logic [3:0]  avm_byteenable;

    always #5 clk = ~clk;

    lsu_avalon_bridge #(.ADDR_W(32), .RD_TIMEOUT(RD_TO)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_fault(mem_fault),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          o_stall, o_cmd, o_fault, o_wr_acc, o_rd_acc;
    bit          o_unstable, o_both;
    logic [31:0] o_addr, o_wd, o_rdata;
    logic [3:0]  o_be;

    int          e_stall, e_cmd, e_fault, e_wr_acc, e_rd_acc;
    logic [31:0] e_addr, e_wd, e_rdata;
    logic [3:0]  e_be;
    logic [31:0] model_rdata = 32'h0;

    task automatic idle_inputs();
        mem_we = 1'b0; mem_re = 1'b0; mem_addr = '0; mem_wdata = '0; mem_size = '0;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    endtask

    // Reference: what one request should look like on the bus and at the pipeline
    task automatic model(input bit we, input bit re, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int n_wait, input int rdv_lat, input logic [31:0] rd_word);
        int lo;
        bit is_b, is_h, mis, tmo;
        logic [31:0] v;
        lo   = int'(addr[1:0]);
        is_b = (size[1:0] == 2'b00);
        is_h = (size[1:0] == 2'b01);
        mis  = (is_h && addr[0]) || (!is_b && !is_h && lo != 0);
        e_addr = addr & 32'hFFFF_FFFC;
        e_be   = is_b ? 4'(1 << lo) : (is_h ? 4'(3 << lo) : 4'hF);
        e_wd   = is_b ? (wdata & 32'hFF) * 32'h0101_0101 :
                 (is_h ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata);
        e_stall = 0; e_cmd = 0; e_fault = 0; e_wr_acc = 0; e_rd_acc = 0;
        if (mis) begin
            e_fault = 1;
        end else if (we) begin
            e_stall = n_wait + 2; e_cmd = n_wait + 1; e_wr_acc = 1;
        end else if (re) begin
            tmo = (rdv_lat < 0) || (rdv_lat > RD_TO);
            e_cmd = n_wait + 1; e_rd_acc = 1;
            e_stall = n_wait + 2 + (tmo ? RD_TO : rdv_lat);
            if (tmo) begin
                e_fault = 1; model_rdata = 32'h0;
            end else begin
                v = rd_word >> (8 * lo);
                if (is_b) begin
                    v = v & 32'hFF;
                    if (!size[2] && v >= 32'd128) v = v - 32'd256;
                end else if (is_h) begin
                    v = v & 32'hFFFF;
                    if (!size[2] && v >= 32'd32768) v = v - 32'd65536;
                end
                model_rdata = v;
            end
        end
        e_rdata = model_rdata;
    endtask

    // Drives one request held while stalled, plays an Avalon slave, records what happened
    task automatic run_access(input bit we, input bit re, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int n_wait, input int rdv_lat, input logic [31:0] rd_word);
        int wait_left, acc_cyc;
        bit snap, done, wr, rd;
        model(we, re, size, addr, wdata, n_wait, rdv_lat, rd_word);
        o_stall = 0; o_cmd = 0; o_fault = 0; o_wr_acc = 0; o_rd_acc = 0;
        o_unstable = 0; o_both = 0; o_addr = '0; o_wd = '0; o_be = '0;
        wait_left = n_wait; acc_cyc = -1; snap = 0; done = 0;
        @(posedge clk); #1;
        mem_we = we; mem_re = re; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            wr = avm_write; rd = avm_read;
            avm_waitrequest = (wr || rd) && (wait_left > 0);
            if (rd && wait_left == 0) acc_cyc = c;
            if ((wr || rd) && wait_left > 0) wait_left--;
            avm_readdatavalid = 1'b0;
            avm_readdata = $urandom;
            if (acc_cyc >= 0 && rdv_lat >= 0 && c == acc_cyc + rdv_lat) begin
                avm_readdatavalid = 1'b1; avm_readdata = rd_word;
            end
            if (wr && rd) o_both = 1;
            if (wr || rd) begin
                o_cmd++;
                if (!snap) begin
                    snap = 1; o_addr = avm_address; o_wd = avm_writedata; o_be = avm_byteenable;
                end else if (avm_address !== o_addr || avm_byteenable !== o_be ||
                             (wr && avm_writedata !== o_wd)) begin
                    o_unstable = 1;
                end
                if (!avm_waitrequest) begin
                    if (wr) o_wr_acc++; else o_rd_acc++;
                end
            end
            @(negedge clk);
            if (mem_stall) o_stall++; else done = 1;
            if (mem_fault) o_fault++;
        end
        // After release: a stray readdatavalid must be ignored and nothing reissued
        @(posedge clk); #1;
        mem_we = 1'b0; mem_re = 1'b0; avm_waitrequest = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = $urandom;
        @(negedge clk);
        if (mem_fault) o_fault++;
        if (avm_read || avm_write) o_cmd++;
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        if (mem_fault) o_fault++;
        o_rdata = mem_rdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        mem_we = 1'b1; mem_size = 3'b010; mem_addr = 32'h100; mem_wdata = 32'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({avm_read, avm_write, avm_byteenable, avm_address, avm_writedata, mem_rdata, mem_fault} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got rd=%b wr=%b be=%h a=%h wd=%h rdata=%h fault=%b want all 0",
                     avm_read, avm_write, avm_byteenable, avm_address, avm_writedata, mem_rdata, mem_fault);
        end
        n_tests++;
        if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", mem_stall); end
        @(posedge clk); #1;
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_sw();
        run_access(1, 0, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, -1, 32'h0);
        n_tests++; if (o_wr_acc !== 1) begin n_fail++; $display("FAIL sw_accepts got %0d want 1", o_wr_acc); end
        n_tests++; if (o_cmd !== 1) begin n_fail++; $display("FAIL sw_cmd_cycles got %0d want 1", o_cmd); end
        n_tests++; if (o_be !== 4'hF) begin n_fail++; $display("FAIL sw_be got %h want f", o_be); end
        n_tests++; if (o_wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", o_wd); end
        n_tests++; if (o_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h want 100", o_addr); end
        n_tests++; if (o_stall !== 2) begin n_fail++; $display("FAIL sw_stall got %0d want 2", o_stall); end
    endtask

    task automatic test_lb();
        run_access(0, 1, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        n_tests++; if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be got %b want 1000", o_be); end
        n_tests++; if (o_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff80", o_rdata); end
        n_tests++; if (o_stall !== 3) begin n_fail++; $display("FAIL lb_stall got %0d want 3", o_stall); end
        run_access(0, 1, 3'b100, 32'h103, 32'h0, 0, 1, 32'h80FF_FFFF);
        n_tests++; if (o_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_rdata got %h want 00000080", o_rdata); end
    endtask

    task automatic test_sh_wait();
        run_access(1, 0, 3'b001, 32'h202, 32'h0000_1234, 3, -1, 32'h0);
        n_tests++; if (o_wd !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata got %h want 12341234", o_wd); end
        n_tests++; if (o_be !== 4'b1100) begin n_fail++; $display("FAIL sh_be got %b want 1100", o_be); end
        n_tests++; if (o_unstable !== 1'b0) begin n_fail++; $display("FAIL sh_stable got unstable=%b want 0", o_unstable); end
        n_tests++; if (o_cmd !== 4) begin n_fail++; $display("FAIL sh_cmd_cycles got %0d want 4", o_cmd); end
        n_tests++; if (o_stall !== 5) begin n_fail++; $display("FAIL sh_stall got %0d want 5", o_stall); end
    endtask

    task automatic test_misaligned();
        run_access(0, 1, 3'b010, 32'h101, 32'h0, 0, 1, 32'h1111_1111);
        n_tests++; if (o_cmd !== 0) begin n_fail++; $display("FAIL mis_bus got %0d cmd cycles want 0", o_cmd); end
        n_tests++; if (o_fault !== 1) begin n_fail++; $display("FAIL mis_fault got %0d pulses want 1", o_fault); end
        n_tests++; if (o_stall !== 0) begin n_fail++; $display("FAIL mis_stall got %0d want 0", o_stall); end
        n_tests++; if (o_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL mis_rdata got %h want 00000080", o_rdata); end
    endtask

    task automatic test_timeout();
        run_access(0, 1, 3'b010, 32'h200, 32'h0, 0, -1, 32'h0);
        n_tests++; if (o_fault !== 1) begin n_fail++; $display("FAIL tmo_fault got %0d pulses want 1", o_fault); end
        n_tests++; if (o_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata got %h want 0", o_rdata); end
        n_tests++; if (o_stall !== RD_TO + 2) begin n_fail++; $display("FAIL tmo_stall got %0d want %0d", o_stall, RD_TO + 2); end
        n_tests++; if (o_cmd !== 1) begin n_fail++; $display("FAIL tmo_cmd_cycles got %0d want 1", o_cmd); end
    endtask

    task automatic test_random();
        bit we, re;
        int k, n_wait, rdv;
        logic [2:0] size;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom_range(0, 1));
            re = we ? 1'($urandom_range(0, 1)) : 1'b1;
            k = we ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
            size = (k < 3) ? 3'(k) : 3'(k + 1);
            n_wait = int'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) rdv = -1;
            else rdv = int'($urandom_range(0, 4));
            run_access(we, re, size, $urandom, $urandom, n_wait, rdv, $urandom);
            n_tests++; if (o_stall !== e_stall) begin n_fail++; $display("FAIL rnd%0d_stall got %0d want %0d", i, o_stall, e_stall); end
            n_tests++; if (o_cmd !== e_cmd) begin n_fail++; $display("FAIL rnd%0d_cmd got %0d want %0d", i, o_cmd, e_cmd); end
            n_tests++; if (o_fault !== e_fault) begin n_fail++; $display("FAIL rnd%0d_fault got %0d want %0d", i, o_fault, e_fault); end
            n_tests++; if (o_wr_acc !== e_wr_acc || o_rd_acc !== e_rd_acc) begin
                n_fail++; $display("FAIL rnd%0d_accepts got wr=%0d rd=%0d want wr=%0d rd=%0d", i, o_wr_acc, o_rd_acc, e_wr_acc, e_rd_acc);
            end
            n_tests++; if (o_rdata !== e_rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, o_rdata, e_rdata); end
            n_tests++; if (o_both !== 1'b0 || o_unstable !== 1'b0) begin
                n_fail++; $display("FAIL rnd%0d_cmd_rules got both=%b unstable=%b want 0 0", i, o_both, o_unstable);
            end
            if (e_cmd > 0) begin
                n_tests++; if (o_addr !== e_addr) begin n_fail++; $display("FAIL rnd%0d_addr got %h want %h", i, o_addr, e_addr); end
                n_tests++; if (o_be !== e_be) begin n_fail++; $display("FAIL rnd%0d_be got %b want %b", i, o_be, e_be); end
            end
            if (e_wr_acc > 0) begin
                n_tests++; if (o_wd !== e_wd) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, o_wd, e_wd); end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        run_access(0, 1, 3'b010, 32'h308, 32'h0, 0, 1, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        mem_re = 1'b1; mem_size = 3'b010; mem_addr = 32'h300;
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (avm_read !== 1'b1) begin n_fail++; $display("FAIL rstmid_read_issued got %b want 1", avm_read); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall got %b want 0", mem_stall); end
        @(posedge clk); #1;
        rst = 1'b0; mem_re = 1'b0;
        avm_readdatavalid = 1'b1; avm_readdata = 32'hCAFE_F00D;
        @(negedge clk);
        n_tests++;
        if ({avm_read, avm_write, mem_fault, mem_stall, avm_byteenable, avm_address, mem_rdata} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got rd=%b wr=%b fault=%b stall=%b be=%h a=%h rdata=%h want all 0",
                     avm_read, avm_write, mem_fault, mem_stall, avm_byteenable, avm_address, mem_rdata);
        end
        @(posedge clk); #1;
        avm_readdatavalid = 1'b0;
        @(negedge clk);
        n_tests++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_late_data got %h want 0", mem_rdata); end
        model_rdata = 32'h0;
        run_access(0, 1, 3'b010, 32'h304, 32'h0, 0, 2, 32'h1357_9BDF);
        n_tests++; if (o_rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rstmid_next_rdata got %h want 13579bdf", o_rdata); end
        n_tests++; if (o_stall !== 4) begin n_fail++; $display("FAIL rstmid_next_stall got %0d want 4", o_stall); end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_lb();
        test_sh_wait();
        test_misaligned();
        test_timeout();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule

// File: doc/lsu_avalon_bridge.md
LSU_AVALON_BRIDGE -- requirements
Module: lsu_avalon_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: width of mem_addr and avm_address.
REQ-002 SHALL have parameter RD_TIMEOUT, default 255: maximum cycles in RD_WAIT before the block aborts.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_addr  input  ADDR_W  byte address from the EX/MEM ALU result.
REQ-006 SHALL have port mem_wdata  input  32  store data, already forwarded.
REQ-007 SHALL have port mem_we  input  1  store request from the MEM stage.
REQ-008 SHALL have port mem_re  input  1  load request from the MEM stage.
REQ-009 SHALL have port mem_size  input  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port mem_rdata  output  32  aligned, extended load result to MEM/WB.
REQ-011 SHALL have port mem_stall  output  1  freezes PC and all pipeline registers while high.
REQ-012 SHALL have port mem_fault  output  1  one-cycle pulse on a misaligned access or a read timeout.
REQ-013 SHALL have port avm_address  output  ADDR_W  word-aligned address (bits [1:0] = 00).
REQ-014 SHALL have ports avm_read and avm_write  output  1 each  Avalon-MM commands.
REQ-015 SHALL have ports avm_writedata (output, 32) and avm_byteenable (output, 4).
REQ-016 SHALL have ports avm_waitrequest (input, 1), avm_readdata (input, 32) and avm_readdatavalid (input, 1).

Function
REQ-017 SHALL implement the states IDLE, WR, RD_REQ, RD_WAIT and DONE.
REQ-018 In IDLE, an aligned request SHALL latch the command (address, data, size, type) and enter WR (store) or RD_REQ (load).
REQ-019 mem_stall SHALL be high combinationally in the IDLE cycle an aligned request is present, and in WR, RD_REQ and RD_WAIT; it SHALL be low in IDLE with no request and in DONE.
REQ-020 When mem_we and mem_re are both high, the store SHALL take priority and the load SHALL be ignored.
REQ-021 Misaligned accesses are H/HU with addr[0]=1, or W with addr[1:0]!=00; for these: no bus command, mem_fault=1 for one cycle, mem_stall=0, mem_rdata unchanged, stay in IDLE.
REQ-022 In WR, avm_write SHALL be held with address, writedata and byteenable stable until a cycle with avm_waitrequest=0, then go to DONE.
REQ-023 In RD_REQ, avm_read SHALL be held stable until avm_waitrequest=0, then go to RD_WAIT; a readdatavalid in the accept cycle itself SHALL be captured and go directly to DONE.
REQ-024 In RD_WAIT, avm_readdatavalid=1 SHALL capture the data and go to DONE; readdatavalid outside RD_REQ/RD_WAIT SHALL be ignored.
REQ-025 A RD_WAIT counter SHALL abort after RD_TIMEOUT cycles: mem_fault pulse, mem_rdata=0, go to DONE.
REQ-026 DONE SHALL last exactly one cycle with mem_stall=0, then return to IDLE, so each request is issued exactly once.
REQ-027 Total latency SHALL be 2 stall cycles for a zero-wait write, and 3 for a read with readdatavalid one cycle after accept.
REQ-028 avm_byteenable SHALL be 0001<<addr[1:0] for B/BU, 0011<<addr[1:0] for H/HU, and 1111 for W.
REQ-029 avm_writedata SHALL be {4{wdata[7:0]}} for B, {2{wdata[15:0]}} for H, and wdata for W.
REQ-030 Load data SHALL be avm_readdata>>(8*addr[1:0]), then sign-extended (B, H) or zero-extended (BU, HU).
REQ-031 mem_rdata SHALL be registered and hold the last load result until the next load completes.
REQ-032 avm_read and avm_write SHALL never be high in the same cycle.

Reset
REQ-033 On rst=1 at a clock edge: state=IDLE; mem_rdata, mem_fault, avm_read, avm_write, avm_byteenable, avm_address and avm_writedata all 0; timeout counter cleared.
REQ-034 Reset mid-transaction SHALL abandon the access, with commands low from the cycle after the edge; late readdatavalid SHALL be ignored.
REQ-035 mem_stall SHALL be 0 while rst=1.

Verification
REQ-036 SW 0xDEADBEEF to 0x100, waitrequest=0 -> one avm_write cycle, byteenable 1111, stall high 2 cycles.
REQ-037 LB from 0x103, readdata=0x80FF_FF_FF -> byteenable 1000, mem_rdata=0xFFFFFF80; with LBU, 0x00000080.
REQ-038 SH 0x1234 to 0x202, waitrequest=1 for 3 cycles -> writedata 0x12341234, byteenable 1100, command stable throughout, stall 5 cycles.
REQ-039 LW from 0x101 -> no bus activity, mem_fault pulse, mem_stall=0.
REQ-040 LW, readdatavalid never asserted -> mem_fault after RD_TIMEOUT cycles, mem_rdata=0, back in IDLE.
REQ-041 rst asserted in RD_WAIT, then readdatavalid -> outputs zero, data ignored; the next LW completes normally.
